// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode-side hazard inputs and per-stage stall/flush controls
interface hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [2:0]       fd_readReg1;
    logic [2:0]       fd_readReg2;
    logic             fd_uses1;
    logic             fd_uses2;
    logic             DX_memRead;
    logic             DX_regWrite;
    logic [2:0]       DX_writeReg;
    logic             redirect;
    logic             imem_stall;
    logic             dmem_stall;
    logic             wb_halt;
    logic             pc_stall;
    logic             FD_stall;
    logic             FD_flush;
    logic             DX_stall;
    logic             DX_flush;
    logic             XM_stall;
    logic             pend_redirect;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output fd_readReg1, fd_readReg2, fd_uses1, fd_uses2,
               DX_memRead, DX_regWrite, DX_writeReg,
               redirect, imem_stall, dmem_stall, wb_halt,
        input  pc_stall, FD_stall, FD_flush, DX_stall, DX_flush, XM_stall,
               pend_redirect, state, stall_cnt
    );

    modport slave (
        input  fd_readReg1, fd_readReg2, fd_uses1, fd_uses2,
               DX_memRead, DX_regWrite, DX_writeReg,
               redirect, imem_stall, dmem_stall, wb_halt,
        output pc_stall, FD_stall, FD_flush, DX_stall, DX_flush, XM_stall,
               pend_redirect, state, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control for load-use, redirect, memory busy and halt
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN = 2'b00, MSTALL = 2'b01, PEND = 2'b10, HALT = 2'b11} state_t;

    state_t           st, st_nx;
    logic [CNT_W-1:0] cnt;
    logic             load_use;
    logic             pc_s, fd_s, fd_f, dx_s, dx_f, xm_s, pend;

    assign load_use = bus.DX_memRead & bus.DX_regWrite &
                      ((bus.fd_uses1 & (bus.fd_readReg1 == bus.DX_writeReg)) |
                       (bus.fd_uses2 & (bus.fd_readReg2 == bus.DX_writeReg)));

    // Controls and next state; MSTALL resolves exactly like RUN since dmem_stall dominates both
    always_comb begin
        {pc_s, fd_s, fd_f, dx_s, dx_f, xm_s, pend} = '0;
        st_nx = st;
        if (st == HALT) begin
            {pc_s, fd_s, dx_s, xm_s} = '1;
        end else if (st == PEND) begin
            pend = 1'b1;
            if (bus.dmem_stall) begin
                {pc_s, fd_s, dx_s, xm_s} = '1;
            end else if (bus.imem_stall) begin
                pc_s = 1'b1;
                fd_f = 1'b1;
            end else begin
                st_nx = RUN;
            end
        end else begin
            st_nx = RUN;
            if (bus.dmem_stall) begin
                {pc_s, fd_s, dx_s, xm_s} = '1;
                st_nx = MSTALL;
            end else if (bus.redirect) begin
                fd_f  = 1'b1;
                dx_f  = 1'b1;
                st_nx = bus.imem_stall ? PEND : RUN;
            end else if (load_use) begin
                pc_s = 1'b1;
                fd_s = 1'b1;
                dx_f = 1'b1;
            end else if (bus.imem_stall) begin
                pc_s = 1'b1;
                fd_f = 1'b1;
            end
        end
        if (bus.wb_halt) st_nx = HALT;
    end

    // State register and saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= RUN;
            cnt <= '0;
        end else begin
            st <= st_nx;
            if (pc_s && !(&cnt)) cnt <= cnt + 1'b1;
        end
    end

    assign bus.pc_stall      = pc_s & ~rst;
    assign bus.FD_stall      = fd_s & ~rst;
    assign bus.FD_flush      = fd_f & ~rst;
    assign bus.DX_stall      = dx_s & ~rst;
    assign bus.DX_flush      = dx_f & ~rst;
    assign bus.XM_stall      = xm_s & ~rst;
    assign bus.pend_redirect = pend & ~rst;
    assign bus.state         = rst ? 2'b00 : st;
    assign bus.stall_cnt     = rst ? '0 : cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
    localparam int CW = 4;
    // {pc_stall, FD_stall, FD_flush, DX_stall, DX_flush, XM_stall, pend_redirect, state[1:0]}
    localparam logic [8:0] Z    = 9'b000000000;
    localparam logic [8:0] LU   = 9'b110010000;
    localparam logic [8:0] RDR  = 9'b001010000;
    localparam logic [8:0] IM   = 9'b101000000;
    localparam logic [8:0] MS0  = 9'b110101000;
    localparam logic [8:0] MS1  = 9'b110101001;
    localparam logic [8:0] RDR1 = 9'b001010001;
    localparam logic [8:0] PIM  = 9'b101000110;
    localparam logic [8:0] PREL = 9'b000000110;
    localparam logic [8:0] PDM  = 9'b110101110;
    localparam logic [8:0] HLT  = 9'b110101011;

    typedef struct packed {
        logic [8:0]    v;
        logic [CW-1:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_cnt = '0;

    hazard_ctrl_if #(.CNT_W(CW)) bus ();
    hazard_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic step(input string tag, input logic r, input int lu, input logic rd,
                        input logic im, input logic dm, input logic wh, input logic [8:0] ev);
        exp_t e;
        exp_t g;
        logic [8:0] obs;
        rst = r;
        bus.DX_memRead  = lu inside {1, 2, 3, 4, 5};
        bus.DX_regWrite = lu inside {1, 2, 3, 5, 6};
        bus.DX_writeReg = 3'd3;
        bus.fd_readReg1 = (lu == 5) ? 3'd4 : (lu inside {1, 3, 4, 6}) ? 3'd3 : 3'd5;
        bus.fd_readReg2 = (lu == 2) ? 3'd3 : 3'd6;
        bus.fd_uses1    = lu inside {1, 4, 5, 6};
        bus.fd_uses2    = lu inside {2, 3};
        bus.redirect    = rd;
        bus.imem_stall  = im;
        bus.dmem_stall  = dm;
        bus.wb_halt     = wh;
        e.v = ev;
        e.c = r ? '0 : exp_cnt;
        q.push_back(e);
        if (r) exp_cnt = '0;
        else if (ev[8] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
        g = q.pop_front();
        obs = {bus.pc_stall, bus.FD_stall, bus.FD_flush, bus.DX_stall, bus.DX_flush,
               bus.XM_stall, bus.pend_redirect, bus.state};
        checks++;
        assert (obs === g.v) else begin
            errors++;
            $error("FAIL %s ctrl got %b exp %b", tag, obs, g.v);
        end
        checks++;
        assert (bus.stall_cnt === g.c) else begin
            errors++;
            $error("FAIL %s stall_cnt got %0d exp %0d", tag, bus.stall_cnt, g.c);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.redirect = 1'b0; bus.imem_stall = 1'b0; bus.dmem_stall = 1'b0; bus.wb_halt = 1'b0;
        @(posedge clk);
        #1;
        step("reset_gate", 1, 1, 1, 1, 1, 0, Z);
        step("idle",       0, 0, 0, 0, 0, 0, Z);
        step("lu_rs",      0, 1, 0, 0, 0, 0, LU);
        step("lu_after",   0, 0, 0, 0, 0, 0, Z);
        step("lu_rt",      0, 2, 0, 0, 0, 0, LU);
        step("no_uses",    0, 3, 0, 0, 0, 0, Z);
        step("no_regwr",   0, 4, 0, 0, 0, 0, Z);
        step("reg_miss",   0, 5, 0, 0, 0, 0, Z);
        step("not_load",   0, 6, 0, 0, 0, 0, Z);
        step("redirect",   0, 0, 1, 0, 0, 0, RDR);
        step("redir_after",0, 0, 0, 0, 0, 0, Z);
        step("redir_im",   0, 0, 1, 1, 0, 0, RDR);
        repeat (3) step("pend_im", 0, 0, 0, 1, 0, 0, PIM);
        step("pend_rel",   0, 0, 0, 0, 0, 0, PREL);
        step("pend_done",  0, 0, 0, 0, 0, 0, Z);
        step("dm_first",   0, 1, 1, 0, 1, 0, MS0);
        repeat (4) step("mstall", 0, 1, 1, 0, 1, 0, MS1);
        step("dm_release", 0, 1, 1, 0, 0, 0, RDR1);
        step("dm_done",    0, 0, 0, 0, 0, 0, Z);
        step("redir_im2",  0, 0, 1, 1, 0, 0, RDR);
        step("pend_dm",    0, 0, 0, 1, 1, 0, PDM);
        step("pend_im2",   0, 0, 0, 1, 0, 0, PIM);
        step("pend_rel2",  0, 0, 0, 0, 0, 0, PREL);
        step("pend_done2", 0, 0, 0, 0, 0, 0, Z);
        repeat (20) step("imem_sat", 0, 0, 0, 1, 0, 0, IM);
        step("sat_idle",   0, 0, 0, 0, 0, 0, Z);
        step("redir_im3",  0, 0, 1, 1, 0, 0, RDR);
        step("rst_pend",   1, 0, 0, 1, 0, 0, Z);
        step("pend_drop",  0, 0, 0, 0, 0, 0, Z);
        step("lu_post",    0, 1, 0, 0, 0, 0, LU);
        step("halt_enter", 0, 0, 0, 0, 0, 1, Z);
        repeat (3) step("halt", 0, 0, 0, 0, 0, 0, HLT);
        step("halt_redir", 0, 1, 1, 1, 0, 0, HLT);
        step("halt_rst",   1, 0, 0, 0, 0, 0, Z);
        step("post_rst",   0, 0, 0, 0, 0, 0, Z);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
